// File: rtl/ttl_counter_pkg.sv
// ttl_counter_pkg
//   Shared definitions for the counter library models.
//   - DIR_UP / DIR_DN : encodings of the direction input
//   - lim_hi()        : top of the count range for a given modulus
//   - tpd_t / tpd_*   : min:typ:max propagation-delay triple and helpers,
//                       kept here so every counter model describes its
//                       output timing the same way
package ttl_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Highest value reached in the count range 0..modulus-1.
  function automatic longint lim_hi(input longint modulus);
    return modulus - 64'sd1;
  endfunction

  // Output propagation delay triple, in simulation time units.
  typedef struct packed {
    int unsigned t_min;
    int unsigned t_typ;
    int unsigned t_max;
  } tpd_t;

  function automatic tpd_t tpd_make(input int t_min, input int t_typ,
                                    input int t_max);
    tpd_t t;
    t.t_min = int'(t_min);
    t.t_typ = int'(t_typ);
    t.t_max = int'(t_max);
    return t;
  endfunction

  // A triple is well formed when every value is non-negative and ordered.
  function automatic bit tpd_legal(input int t_min, input int t_typ,
                                   input int t_max);
    return (t_min >= 0) && (t_typ >= t_min) && (t_max >= t_typ);
  endfunction

endpackage

// File: rtl/updown_next.sv
// updown_next
//   Purely combinational next-count and terminal-detect logic for the
//   up/down counter. Holds no state.
// Parameters
//   WIDTH    : counter width in bits
//   MODULUS  : count range is 0..MODULUS-1
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits
// Ports
//   q      in  WIDTH  present count
//   up     in  1      direction, 1 = up, 0 = down
//   q_next out WIDTH  count after one enabled step
//   hit    out 1      the step starts from a limit (MODULUS-1 up, 0 down)
module updown_next
  import ttl_counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter bit     SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] q_next,
  output logic             hit
);

  localparam logic [WIDTH-1:0] LIM  = WIDTH'(lim_hi(MODULUS));
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic at_top;
  logic at_zero;
  logic above_top;

  assign at_top    = (q == LIM);
  assign at_zero   = (q == ZERO);
  // Only reachable after loading d >= MODULUS.
  assign above_top = (q > LIM);

  always_comb begin
    q_next = q;
    hit    = 1'b0;
    if (up == DIR_UP) begin
      // Out-of-range values are treated like the top limit going up: they
      // wrap to 0 (or hold), but only a genuine MODULUS-1 raises hit.
      if (at_top || above_top) begin
        q_next = SATURATE ? q : ZERO;
      end else begin
        q_next = q + ONE;
      end
      hit = at_top;
    end else begin
      // Going down, an out-of-range value simply decrements.
      if (at_zero) begin
        q_next = SATURATE ? q : LIM;
      end else begin
        q_next = q - ONE;
      end
      hit = at_zero;
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n
//   Parametrised synchronous up/down counter with synchronous clear,
//   active-low synchronous parallel load and active-low ripple
//   carry/borrow for cascading. One clock; all state changes on the rising
//   edge.
// Parameters
//   WIDTH                      : counter width in bits (1..32)
//   MODULUS                    : count range 0..MODULUS-1 (2..2^WIDTH)
//   SATURATE                   : 0 = wrap at the limits, 1 = hold
//   tPD_min / tPD_typ / tPD_max: output delay triple for timing annotation
// Ports
//   clk    in  1      clock, rising edge
//   clr    in  1      synchronous clear, active high, highest priority
//   load   in  1      synchronous parallel load, active low
//   en     in  1      local count enable, active high
//   cin    in  1      cascade enable, active high; also gates carry/borrow
//   up     in  1      direction, 1 = up, 0 = down
//   d      in  WIDTH  parallel load data (may exceed MODULUS-1)
//   q      out WIDTH  registered count
//   carry  out 1      active low: q at MODULUS-1, counting up, cin high
//   borrow out 1      active low: q at 0, counting down, cin high
//   tc     out 1      registered pulse: the last count step left a limit
//
// Cascading: the next stage's cin is driven from ~carry (up) or ~borrow
// (down) of this stage; every stage shares clk and en. carry/borrow are
// decoded from the registered q without en so the ripple enable is
// already settled before the edge on which the lower stage wraps.
module updown_counter_n
  import ttl_counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter bit     SATURATE = 1'b0,
  parameter int     tPD_min  = 0,
  parameter int     tPD_typ  = 0,
  parameter int     tPD_max  = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             borrow,
  output logic             tc
);

  // Elaboration-time parameter legality.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_n: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
    $error("updown_counter_n: MODULUS=%0d outside 2..2^WIDTH", MODULUS);
  end
  if (!tpd_legal(tPD_min, tPD_typ, tPD_max)) begin : g_bad_tpd
    $error("updown_counter_n: tPD triple %0d:%0d:%0d not ordered",
           tPD_min, tPD_typ, tPD_max);
  end

  // The synthesizable model is zero-delay: the tPD triple is carried for
  // back-annotation only, so cascades remain cycle-exact.
  localparam tpd_t TPD = tpd_make(tPD_min, tPD_typ, tPD_max);
  localparam logic [WIDTH-1:0] LIM  = WIDTH'(lim_hi(MODULUS));
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic [WIDTH-1:0] q_next;
  logic             hit;
  logic             count_en;

  updown_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .q      (q_r),
    .up     (up),
    .q_next (q_next),
    .hit    (hit)
  );

  assign count_en = en & cin;

  // Priority: clr > load (low) > count > hold. tc is a pulse, so every
  // branch that does not take a count step clears it.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_r  <= ZERO;
      tc_r <= 1'b0;
    end else if (!load) begin
      q_r  <= d;
      tc_r <= 1'b0;
    end else if (count_en) begin
      q_r  <= q_next;
      tc_r <= hit;
    end else begin
      q_r  <= q_r;
      tc_r <= 1'b0;
    end
  end

  assign q      = q_r;
  assign tc     = tc_r;
  assign carry  = ~((q_r == LIM)  && (up == DIR_UP) && cin);
  assign borrow = ~((q_r == ZERO) && (up == DIR_DN) && cin);

  // Keeps the delay triple referenced in the elaborated design.
  logic tpd_unused;
  assign tpd_unused = ^{TPD.t_min, TPD.t_typ, TPD.t_max};

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n: binary wrap, decade down, saturate,
// priority, out-of-range load, two-stage cascade and enable gating.
module tb_updown_counter_n;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // binary, WIDTH=4 MODULUS=16 wrap
  logic       b_load, b_en, b_cin, b_up;
  logic [3:0] b_d, b_q;
  logic       b_carry, b_borrow, b_tc;
  // decade, MODULUS=10 wrap
  logic       dc_load, dc_en, dc_cin, dc_up;
  logic [3:0] dc_d, dc_q;
  logic       dc_carry, dc_borrow, dc_tc;
  // decade, MODULUS=10 saturate
  logic       s_load, s_en, s_cin, s_up;
  logic [3:0] s_d, s_q;
  logic       s_carry, s_borrow, s_tc;
  // two-stage cascade, MODULUS=16 each
  logic       c_load, c_en, c_cin, c_up;
  logic [3:0] c_lo_d, c_hi_d, c_lo_q, c_hi_q;
  logic       c_lo_carry, c_lo_borrow, c_lo_tc;
  logic       c_hi_carry, c_hi_borrow, c_hi_tc, c_hi_cin;

  assign c_hi_cin = ~(c_lo_carry & c_lo_borrow);

  updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_bin (
    .clk(clk), .clr(clr), .load(b_load), .en(b_en), .cin(b_cin), .up(b_up),
    .d(b_d), .q(b_q), .carry(b_carry), .borrow(b_borrow), .tc(b_tc));

  updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_dec (
    .clk(clk), .clr(clr), .load(dc_load), .en(dc_en), .cin(dc_cin),
    .up(dc_up), .d(dc_d), .q(dc_q), .carry(dc_carry), .borrow(dc_borrow),
    .tc(dc_tc));

  updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .clr(clr), .load(s_load), .en(s_en), .cin(s_cin), .up(s_up),
    .d(s_d), .q(s_q), .carry(s_carry), .borrow(s_borrow), .tc(s_tc));

  updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_lo (
    .clk(clk), .clr(clr), .load(c_load), .en(c_en), .cin(c_cin), .up(c_up),
    .d(c_lo_d), .q(c_lo_q), .carry(c_lo_carry), .borrow(c_lo_borrow),
    .tc(c_lo_tc));

  updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_hi (
    .clk(clk), .clr(clr), .load(c_load), .en(c_en), .cin(c_hi_cin),
    .up(c_up), .d(c_hi_d), .q(c_hi_q), .carry(c_hi_carry),
    .borrow(c_hi_borrow), .tc(c_hi_tc));

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1;
    b_load = 1'b1;  b_en = 1'b1;  b_cin = 1'b1;  b_up = 1'b1;  b_d = 4'd0;
    dc_load = 1'b1; dc_en = 1'b0; dc_cin = 1'b1; dc_up = 1'b0; dc_d = 4'd0;
    s_load = 1'b1;  s_en = 1'b0;  s_cin = 1'b1;  s_up = 1'b1;  s_d = 4'd0;
    c_load = 1'b1;  c_en = 1'b0;  c_cin = 1'b1;  c_up = 1'b1;
    c_lo_d = 4'd0;  c_hi_d = 4'd0;

    // reset
    tick();
    check("rst_b_q", b_q, 4'd0);
    check("rst_b_tc", b_tc, 1'b0);
    check("rst_b_carry", b_carry, 1'b1);
    check("rst_b_borrow", b_borrow, 1'b1);
    check("rst_dc_borrow", dc_borrow, 1'b0);
    check("rst_dc_carry", dc_carry, 1'b1);
    clr = 1'b0;

    // binary wrap
    repeat (15) tick();
    check("bin_q15", b_q, 4'd15);
    check("bin_tc15", b_tc, 1'b0);
    check("bin_carry15", b_carry, 1'b0);
    tick();
    check("bin_wrap_q", b_q, 4'd0);
    check("bin_wrap_tc", b_tc, 1'b1);
    check("bin_wrap_carry", b_carry, 1'b1);
    tick();
    check("bin_after_q", b_q, 4'd1);
    check("bin_after_tc", b_tc, 1'b0);

    // decade down from 0
    dc_load = 1'b0; dc_d = 4'd0;
    tick();
    dc_load = 1'b1;
    check("dec_load0_q", dc_q, 4'd0);
    check("dec_borrow0", dc_borrow, 1'b0);
    dc_en = 1'b1;
    tick();
    check("dec_wrap_q", dc_q, 4'd9);
    check("dec_wrap_tc", dc_tc, 1'b1);
    check("dec_wrap_borrow", dc_borrow, 1'b1);
    tick();
    check("dec_8_q", dc_q, 4'd8);
    check("dec_8_tc", dc_tc, 1'b0);
    dc_en = 1'b0;

    // priority: clr beats load
    clr = 1'b1; dc_load = 1'b0; dc_d = 4'd5;
    tick();
    check("pri_clr_q", dc_q, 4'd0);
    clr = 1'b0; dc_d = 4'd7; dc_en = 1'b1;
    tick();
    check("pri_load_q", dc_q, 4'd7);
    check("pri_load_tc", dc_tc, 1'b0);
    // out-of-range load then count up: wraps to 0 without tc
    dc_d = 4'd12;
    tick();
    check("oor_load_q", dc_q, 4'd12);
    dc_load = 1'b1; dc_up = 1'b1;
    tick();
    check("oor_up_q", dc_q, 4'd0);
    check("oor_up_tc", dc_tc, 1'b0);
    // out-of-range load then count down: plain decrement
    dc_load = 1'b0;
    tick();
    dc_load = 1'b1; dc_up = 1'b0;
    tick();
    check("oor_dn_q", dc_q, 4'd11);
    check("oor_dn_tc", dc_tc, 1'b0);
    dc_en = 1'b0;

    // saturate
    s_load = 1'b0; s_d = 4'd8;
    tick();
    s_load = 1'b1;
    check("sat_load_q", s_q, 4'd8);
    s_en = 1'b1;
    tick();
    check("sat_9_q", s_q, 4'd9);
    check("sat_9_tc", s_tc, 1'b0);
    tick();
    check("sat_hold1_q", s_q, 4'd9);
    check("sat_hold1_tc", s_tc, 1'b1);
    tick();
    check("sat_hold2_q", s_q, 4'd9);
    check("sat_hold2_tc", s_tc, 1'b1);
    s_up = 1'b0;
    tick();
    check("sat_dn_q", s_q, 4'd8);
    check("sat_dn_tc", s_tc, 1'b0);
    s_load = 1'b0; s_d = 4'd0;
    tick();
    s_load = 1'b1;
    tick();
    check("sat_zero_q", s_q, 4'd0);
    check("sat_zero_tc", s_tc, 1'b1);
    s_en = 1'b0;

    // cascade from 0x0F
    c_load = 1'b0; c_lo_d = 4'hF; c_hi_d = 4'h0;
    tick();
    c_load = 1'b1;
    check("cas_load", {c_hi_q, c_lo_q}, 8'h0F);
    check("cas_lo_carry", c_lo_carry, 1'b0);
    c_en = 1'b1;
    tick();
    check("cas_up", {c_hi_q, c_lo_q}, 8'h10);
    check("cas_lo_carry_after", c_lo_carry, 1'b1);
    check("cas_lo_tc", c_lo_tc, 1'b1);
    check("cas_hi_tc", c_hi_tc, 1'b0);
    c_up = 1'b0;
    #1;
    check("cas_lo_borrow", c_lo_borrow, 1'b0);
    tick();
    check("cas_dn", {c_hi_q, c_lo_q}, 8'h0F);
    check("cas_dn_lo_tc", c_lo_tc, 1'b1);
    c_en = 1'b0;

    // enable gating on the binary counter
    b_load = 1'b0; b_d = 4'd15;
    tick();
    b_load = 1'b1; b_en = 1'b0; b_up = 1'b1;
    tick();
    check("gate_en0_q", b_q, 4'd15);
    check("gate_en0_tc", b_tc, 1'b0);
    check("gate_en0_carry", b_carry, 1'b0);
    b_cin = 1'b0;
    #1;
    check("gate_cin0_carry", b_carry, 1'b1);
    b_en = 1'b1;
    tick();
    check("gate_cin0_q", b_q, 4'd15);
    check("gate_cin0_tc", b_tc, 1'b0);
    b_cin = 1'b1;
    #1;
    check("gate_cin1_carry", b_carry, 1'b0);
    b_up = 1'b0;
    #1;
    check("dir_carry", b_carry, 1'b1);
    check("dir_borrow", b_borrow, 1'b1);
    b_up = 1'b1;

    // clr mid-count suppresses the pending tc
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("midclr_q", b_q, 4'd0);
    check("midclr_tc", b_tc, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
